pc_loader: RTL and testbench

//  Instruction-fetch front end of the RISC-V core.
//  - Holds the program counter (PC) in a register and loads it each cycle from one of two sources:
//    the sequential address or the jump address.
//  - Drives the PC into an internal instruction ROM, which returns the addressed 32-bit instruction

---
 rtl/pc_loader_pkg.sv | 16 +
 rtl/pc_loader_inst_rom.sv | 20 ++
 rtl/pc_loader.sv | 43 ++++
 tb/tb_pc_loader.sv | 107 ++++++++++
 4 files changed

// File: rtl/pc_loader_pkg.sv
// Shared widths and constants for the instruction-fetch front end.
// Latency: n/a (declarations only). Backpressure: n/a.
// The NOP constant is the word substituted for squashed fetches.
package pc_loader_pkg;

    localparam int PC_ADDR_W = 6;
    localparam int INST_W    = 32;
    localparam int ROM_DEPTH = 1 << PC_ADDR_W;

    typedef logic [PC_ADDR_W-1:0] mem_addr_t;
    typedef logic [INST_W-1:0]    data_size_t;

    // addi x0, x0, 0
    localparam data_size_t NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/pc_loader_inst_rom.sv
// Word-addressed instruction ROM with a flush mask on the read data.
// Latency: 0 cycles, inst follows addr/flush combinationally.
// Backpressure: none; contents are loaded by backdoor into mem and never written by logic.
module inst_rom #(
    parameter int                ADDR_W   = pc_loader_pkg::PC_ADDR_W,
    parameter int                DATA_W   = pc_loader_pkg::INST_W,
    parameter int                DEPTH    = pc_loader_pkg::ROM_DEPTH,
    parameter logic [DATA_W-1:0] NOP_INST = pc_loader_pkg::NOP_INST
) (
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] inst
);

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // flush only masks the read; storage is untouched
    assign inst = flush ? NOP_INST : mem[addr];

endmodule

// File: rtl/pc_loader.sv
// Fetch front end: PC register selecting sequential or jump target, feeding the instruction ROM.
// Latency: 1 cycle from addrIn/addrJump to addrOut; 0 cycles from addrOut/flush to inst.
// Backpressure: enable=0 stalls the PC in place; flush squashes the fetched word to a NOP.
module pc_loader
    import pc_loader_pkg::*;
#(
    parameter int                ADDR_W    = PC_ADDR_W,
    parameter int                DATA_W    = INST_W,
    parameter int                DEPTH     = ROM_DEPTH,
    parameter string             INIT_FILE = "./data",
    parameter logic [DATA_W-1:0] NOP_WORD  = NOP_INST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              select,
    input  logic [ADDR_W-1:0] addrIn,
    input  logic [ADDR_W-1:0] addrJump,
    input  logic              flush,
    output logic [ADDR_W-1:0] addrOut,
    output logic [DATA_W-1:0] inst
);

    // Reset outranks enable; no initial value, so the PC is unknown until the first reset edge.
    always_ff @(posedge clk) begin
        if (reset)
            addrOut <= '0;
        else if (enable)
            addrOut <= select ? addrJump : addrIn;
    end

    inst_rom #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .NOP_INST(NOP_WORD)
    ) rom1 (
        .flush(flush),
        .addr (addrOut),
        .inst (inst)
    );

endmodule

// File: tb/tb_pc_loader.sv
// Directed bench for pc_loader: reference PC model plus backdoor-loaded ROM image,
// expectations queued at drive time and compared one cycle later.
module tb_pc_loader;

    localparam int          AW  = 6;
    localparam int          DW  = 32;
    localparam int          DEP = 64;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        logic [AW-1:0] pc;
        logic [DW-1:0] ins;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset, enable, select, flush;
    logic [AW-1:0] addrIn, addrJump;
    logic [AW-1:0] addrOut;
    logic [DW-1:0] inst;

    logic [DW-1:0] rom_model [0:DEP-1];
    logic [AW-1:0] pc_model;
    exp_t          sb [$];
    int            checks   = 0;
    int            failures = 0;

    pc_loader dut (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .select  (select),
        .addrIn  (addrIn),
        .addrJump(addrJump),
        .flush   (flush),
        .addrOut (addrOut),
        .inst    (inst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, queue the model's expectation, then compare after the edge.
    task automatic step(input string tag, input logic r, input logic e, input logic s,
                        input logic [AW-1:0] ai, input logic [AW-1:0] aj, input logic f);
        exp_t x;
        reset = r; enable = e; select = s; addrIn = ai; addrJump = aj; flush = f;
        if (r)      pc_model = '0;
        else if (e) pc_model = s ? aj : ai;
        x.pc  = pc_model;
        x.ins = f ? NOP : rom_model[pc_model];
        sb.push_back(x);
        @(posedge clk);
        #1;
        x = sb.pop_front();
        chk({tag, ".pc"},   {{(DW-AW){1'b0}}, addrOut}, {{(DW-AW){1'b0}}, x.pc});
        chk({tag, ".inst"}, inst, x.ins);
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; select = 1'b0; flush = 1'b0;
        addrIn = '0; addrJump = '0;
        pc_model = '0;
        for (int i = 0; i < DEP; i++) begin
            rom_model[i]     = 32'hA500_0000 | (i << 12) | (i * 3 + 1);
            dut.rom1.mem[i]  = rom_model[i];
        end

        @(negedge clk);
        step("reset",   1'b1, 1'b0, 1'b0, 6'd0,  6'd0,  1'b0);
        step("seq",     1'b0, 1'b1, 1'b0, 6'd1,  6'd0,  1'b0);
        step("jump63",  1'b0, 1'b1, 1'b1, 6'd1,  6'd63, 1'b0);
        for (int k = 0; k < 3; k++)
            step("hold",    1'b0, 1'b0, 1'b0, 6'd5,  6'd9,  1'b0);

        step("seq1",    1'b0, 1'b1, 1'b0, 6'd1,  6'd0,  1'b0);
        // flush with no clock edge: output masks immediately, PC untouched
        flush = 1'b1;
        #1;
        chk("flush_nop",  inst, NOP);
        chk("flush_pc",   {{(DW-AW){1'b0}}, addrOut}, 32'd1);
        flush = 1'b0;
        #1;
        chk("unflush",    inst, rom_model[1]);
        chk("unflush_pc", {{(DW-AW){1'b0}}, addrOut}, 32'd1);

        step("flush_ld",  1'b0, 1'b1, 1'b0, 6'd10, 6'd0,  1'b1);
        step("rst_prio",  1'b1, 1'b1, 1'b1, 6'd0,  6'd7,  1'b0);
        step("rel_jump",  1'b0, 1'b1, 1'b1, 6'd0,  6'd7,  1'b0);
        step("rst_flush", 1'b1, 1'b1, 1'b0, 6'd33, 6'd0,  1'b1);

        for (int k = 0; k < 12; k++)
            step("rand", ($urandom_range(0, 9) == 0), $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, AW'($urandom), AW'($urandom),
                 $urandom_range(0, 3) == 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
